// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad model: closes the addressed contact for HOLD_SCANS column rotations, then opens it for RELEASE_SCANS rotations.
// Latency: row follows col by 1 cycle; command accepted at edge N is busy from N+1; done pulses on the final release scan-start.
// Backpressure: cmd_ready only while idle; commands offered while busy are dropped. Optional KEYPAD_EMU_BOUNCE_EN adds a contact bounce.
module keypad_emulator #(
    parameter int HOLD_SCANS    = 4,
    parameter int RELEASE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_key,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done
);

    // A programmed count of zero is treated as one rotation.
    localparam logic [7:0] HOLD_N    = (HOLD_SCANS < 1)    ? 8'd1 : 8'(HOLD_SCANS);
    localparam logic [7:0] RELEASE_N = (RELEASE_SCANS < 1) ? 8'd1 : 8'(RELEASE_SCANS);

`ifdef KEYPAD_EMU_BOUNCE_EN
    typedef enum logic [2:0] {IDLE, PRESS, RELEASE, BOUNCE_C, BOUNCE_O} state_t;
    localparam state_t FIRST_ST = BOUNCE_C;
`else
    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;
    localparam state_t FIRST_ST = PRESS;
`endif

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic [1:0] key_c;
    logic [1:0] key_r;
    logic [3:0] col_d;
    logic       scan_start;
    logic       contact;

    // Key code to {column, row} position on the matrix.
    function automatic logic [3:0] key_pos(input logic [3:0] k);
        logic [3:0] p;
        p = 4'h0;
        case (k)
            4'hD: p = {2'd0, 2'd0};
            4'hC: p = {2'd0, 2'd1};
            4'hB: p = {2'd0, 2'd2};
            4'hA: p = {2'd0, 2'd3};
            4'hF: p = {2'd1, 2'd0};
            4'h9: p = {2'd1, 2'd1};
            4'h6: p = {2'd1, 2'd2};
            4'h3: p = {2'd1, 2'd3};
            4'h0: p = {2'd2, 2'd0};
            4'h8: p = {2'd2, 2'd1};
            4'h5: p = {2'd2, 2'd2};
            4'h2: p = {2'd2, 2'd3};
            4'hE: p = {2'd3, 2'd0};
            4'h7: p = {2'd3, 2'd1};
            4'h4: p = {2'd3, 2'd2};
            default: p = {2'd3, 2'd3};
        endcase
        return p;
    endfunction

    // A rotation begins when column 0 is freshly selected.
    assign scan_start = (col == 4'b1110) && (col_d != 4'b1110);
    assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // Contact is closed in the hold state and, when enabled, the first bounce phase.
    always_comb begin
        contact = (state == PRESS);
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (state == BOUNCE_C) begin
            contact = 1'b1;
        end
`endif
    end

    // Column history and registered row return, one cycle behind col.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_d <= 4'hF;
            row   <= 4'hF;
        end else begin
            col_d <= col;
            row   <= (contact && !col[key_c]) ? ~(4'b0001 << key_r) : 4'hF;
        end
    end

    // Command sequencer: accept, bounce (optional), hold, release, done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            key_c     <= 2'd0;
            key_r     <= 2'd0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        {key_c, key_r} <= key_pos(cmd_key);
                        cnt            <= 8'd0;
                        state          <= FIRST_ST;
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                BOUNCE_C: begin
                    if (scan_start) begin
                        state <= BOUNCE_O;
                        cnt   <= 8'd0;
                    end
                end
                BOUNCE_O: begin
                    if (scan_start) begin
                        state <= PRESS;
                        cnt   <= 8'd0;
                    end
                end
`endif
                PRESS: begin
                    if (scan_start) begin
                        if (cnt_inc >= HOLD_N) begin
                            state <= RELEASE;
                            cnt   <= 8'd0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                RELEASE: begin
                    if (scan_start) begin
                        if (cnt_inc >= RELEASE_N) begin
                            state     <= IDLE;
                            cnt       <= 8'd0;
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 8'd0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with HOLD_SCANS=2, RELEASE_SCANS=2.
// col rotates 1110->1101->1011->0111, 4 cycles per value; commands are accepted on the second cycle of a rotation.
// Also builds with KEYPAD_EMU_BOUNCE_EN defined (bounce adds two rotations and one extra closed window).
module tb_keypad_emulator;

    logic       clk;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic       cmd_valid;
    logic [3:0] cmd_key;
    logic       cmd_ready;
    logic       busy;
    logic       done;

    logic [3:0] ph;
    bit         col_run;
    int         n_vec;
    int         n_bad;

    // Accept on rotation R cycle 1 -> done on the first cycle of rotation R+4 (R+6 with bounce).
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int LAT   = 95;
    localparam int EXTRA = 4;
    localparam int PRE   = 32;
`else
    localparam int LAT   = 63;
    localparam int EXTRA = 0;
    localparam int PRE   = 16;
`endif

    typedef struct {
        logic [3:0] key;
        int         c;
        logic [3:0] exp_row;
        int         lows;
    } vec_t;

    vec_t vt[8];

    keypad_emulator #(
        .HOLD_SCANS   (2),
        .RELEASE_SCANS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .cmd_valid(cmd_valid),
        .cmd_key  (cmd_key),
        .cmd_ready(cmd_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive the column for this cycle, clock once, and sample 1 time unit after the edge.
    task automatic tick();
        if (col_run) col = ~(4'b0001 << ph[3:2]);
        else         col = 4'hF;
        @(posedge clk);
        #1;
        if (col_run) ph = ph + 4'd1;
    endtask

    task automatic wait_ph(input logic [3:0] target);
        for (int i = 0; i < 16 && ph != target; i++) tick();
    endtask

    // Watch an accepted command until done; count closed-contact cycles and illegal row values.
    task automatic observe(input string tag, input int c, input logic [3:0] er, input int elow);
        int low;
        int bad;
        int lat;
        low = 0;
        bad = 0;
        lat = -1;
        for (int i = 1; i <= 140; i++) begin
            tick();
            if (row != 4'hF) begin
                if (row == er && col[c] == 1'b0) low++;
                else bad++;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, " done latency"}, lat, LAT);
        chk({tag, " closed cycles"}, low, elow + EXTRA);
        chk({tag, " bad row cycles"}, bad, 0);
        chk({tag, " ready with done"}, int'(cmd_ready), 1);
    endtask

    task automatic run_vec(input vec_t v);
        string tag;
        tag = $sformatf("key%h", v.key);
        wait_ph(4'd1);
        cmd_key   = v.key;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_key   = ~v.key;
        chk({tag, " busy after accept"}, int'(busy), 1);
        chk({tag, " ready after accept"}, int'(cmd_ready), 0);
        observe(tag, v.c, v.exp_row, v.lows);
        tick();
        chk({tag, " done one cycle"}, int'(done), 0);
        chk({tag, " idle after done"}, int'(busy), 0);
    endtask

    initial begin
        int n_done;
        int n_busy;
        n_vec     = 0;
        n_bad     = 0;
        ph        = 4'd0;
        col_run   = 1'b0;
        col       = 4'hF;
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_key   = 4'h5;

        // key, column, expected row, closed cycles (column-0 keys lose one window cycle to the accept point).
        vt[0] = '{4'h5, 2, 4'b1011, 8};
        vt[1] = '{4'h1, 3, 4'b0111, 8};
        vt[2] = '{4'hD, 0, 4'b1110, 7};
        vt[3] = '{4'hA, 0, 4'b0111, 7};
        vt[4] = '{4'hF, 1, 4'b1110, 8};
        vt[5] = '{4'hE, 3, 4'b1110, 8};
        vt[6] = '{4'h8, 2, 4'b1101, 8};
        vt[7] = '{4'h7, 3, 4'b1101, 8};

        // Reset held two cycles with a command offered.
        tick();
        tick();
        chk("reset row", int'(row), 15);
        chk("reset ready", int'(cmd_ready), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        tick();
        chk("nothing accepted", int'(busy), 0);

        col_run = 1'b1;
        ph      = 4'd0;

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Back-to-back: key 9 then key 0 with cmd_valid held high.
        wait_ph(4'd1);
        cmd_key   = 4'h9;
        cmd_valid = 1'b1;
        tick();
        cmd_key = 4'h0;
        chk("b2b first busy", int'(busy), 1);
        observe("b2b key9", 1, 4'b1101, 8);
        chk("b2b done valid held", int'(cmd_valid), 1);
        tick();
        chk("b2b second busy", int'(busy), 1);
        chk("b2b second ready", int'(cmd_ready), 0);
        chk("b2b done single", int'(done), 0);
        cmd_valid = 1'b0;
        cmd_key   = 4'hF;
        observe("b2b key0", 2, 4'b1110, 8);
        tick();
        chk("b2b idle", int'(busy), 0);

        // Reset in the middle of holding key A.
        wait_ph(4'd1);
        cmd_key   = 4'hA;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < PRE; i++) tick();
        chk("midrst pressed row", int'(row), 7);
        rst = 1'b0;
        tick();
        chk("midrst row", int'(row), 15);
        chk("midrst busy", int'(busy), 0);
        chk("midrst ready", int'(cmd_ready), 1);
        chk("midrst done", int'(done), 0);
        rst    = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("midrst no done", n_done, 0);
        chk("midrst stays idle", n_busy, 0);
        run_vec('{4'h3, 1, 4'b0111, 8});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
